fifo_wr_arbiter: RTL

Shares the single write port of an async_fifo among num_req requesters in the write-clock domain. Uses round-robin arbitration with bounded bursts. Each accepted word is tagged with its source ID so the read side can demultiplex. Sits between the producer blocks and the FIFO's wr_en/din/full pins, clocked by the FIFO's wr_clk.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_wr_arbiter_pkg;

  // Ceiling log2, never less than 1 so a 1-entry field still has a bit.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Width of the in-burst beat counter: holds 0..max_burst-1 without wrapping.
  function automatic int beat_width(input int max_burst);
    return log2c(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_grant,
// scanning upward modulo num_req. Kept generic for reuse on the read side.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int num_req  = 4,
  parameter int id_width = log2c(num_req)
) (
  input  logic [num_req-1:0]  req,
  input  logic [id_width-1:0] last_grant,
  output logic                any_req,
  output logic [id_width-1:0] next_id
);

  int idx;

  // Scan from the farthest candidate down to the nearest so the nearest wins.
  always_comb begin
    any_req = 1'b0;
    next_id = '0;
    idx     = 0;
    for (int k = num_req; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % num_req;
      if (req[idx]) begin
        any_req = 1'b1;
        next_id = id_width'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one async_fifo write port.
// Every accepted word is tagged {source id, payload}; one idle cycle
// separates consecutive grants. Runs on the FIFO's write clock.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int num_req    = 4,
  parameter int data_width = 8,
  parameter int max_burst  = 4,
  parameter int id_width   = log2c(num_req)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [num_req-1:0]             req_valid,
  input  logic [num_req*data_width-1:0]  req_data,
  output logic [num_req-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_wr_en,
  output logic [id_width+data_width-1:0] fifo_din,
  output logic                           grant_valid,
  output logic [id_width-1:0]            grant_id
);

  localparam logic IDLE  = 1'b0;
  localparam logic BURST = 1'b1;
  localparam int   BW    = beat_width(max_burst);

  logic                state_q, state_d;
  logic [id_width-1:0] grant_id_q, grant_id_d;
  logic [id_width-1:0] last_grant_q, last_grant_d;
  logic [BW-1:0]       beat_cnt_q, beat_cnt_d;

  logic [num_req-1:0][data_width-1:0] req_data_a;
  logic                               pick_any;
  logic [id_width-1:0]                pick_id;
  logic                               holder_valid;
  logic                               last_beat;
  logic                               xfer;

  assign req_data_a = req_data;

  fifo_wr_arbiter_rr_pick #(
    .num_req  (num_req),
    .id_width (id_width)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .any_req    (pick_any),
    .next_id    (pick_id)
  );

  assign holder_valid = req_valid[grant_id_q];
  assign last_beat    = (beat_cnt_q == BW'(max_burst - 1));

  // A write only happens while bursting, the holder has data, the FIFO has
  // room, and no reset is dropping the grant this cycle.
  assign xfer       = (state_q == BURST) & holder_valid & ~fifo_full & ~rst;
  assign fifo_wr_en = xfer;
  assign fifo_din   = {grant_id_q, req_data_a[grant_id_q]};

  assign grant_valid = (state_q == BURST);
  assign grant_id    = grant_id_q;

  // Only the holder sees ready, and only when the FIFO can take a word.
  for (genvar gi = 0; gi < num_req; gi++) begin : g_ready
    assign req_ready[gi] = (state_q == BURST) & (grant_id_q == id_width'(gi))
                         & ~fifo_full & ~rst;
  end

  // Arbitration and burst bookkeeping.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    if (state_q == IDLE) begin
      if (pick_any) begin
        state_d    = BURST;
        grant_id_d = pick_id;
        beat_cnt_d = '0;
      end
    end else begin
      // A full FIFO freezes everything: grant held, count unchanged.
      if (!fifo_full) begin
        if (!holder_valid || last_beat) begin
          state_d      = IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
    end
  end

  // State registers; reset makes requester 0 the first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= id_width'(num_req - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule
